// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-three), one bit per clock,
// with a start/ready/busy/done handshake for the display path.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | one add-3/shift iteration per edge, busy=1
// DONE  | one-cycle done pulse, bcd valid, start accepted back-to-back
module seq_bin2bcd #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int DW    = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   if ((64'd10 ** DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_param_check
      $error("seq_bin2bcd: DIGITS too small to represent 2**BIN_W-1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state;
   logic [BIN_W-1:0]   bin_sr;
   logic [DW-1:0]      dig;
   logic [DW-1:0]      dig_corr;
   logic [DW-1:0]      dig_next;
   logic [CNT_W-1:0]   count;
   logic               last_iter;

   // The top bit of the top digit is dropped by the shift; unreachable when
   // DIGITS is large enough.
   always_comb begin
      dig_corr = dig;
      for (int k = 0; k < DIGITS; k++) begin
         if (dig[4*k +: 4] >= 4'd5) begin
            dig_corr[4*k +: 4] = dig[4*k +: 4] + 4'd3;
         end
      end
      dig_next  = (dig_corr << 1) | DW'(bin_sr[BIN_W-1]);
      last_iter = (count == CNT_W'(BIN_W - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         bin_sr <= '0;
         dig    <= '0;
         count  <= '0;
         bcd    <= '0;
         ready  <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  bin_sr <= bin;
                  dig    <= '0;
                  count  <= '0;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
                  state  <= S_SHIFT;
               end else begin
                  ready  <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            S_SHIFT: begin
               dig    <= dig_next;
               bin_sr <= bin_sr << 1;
               count  <= count + CNT_W'(1);
               if (last_iter) begin
                  bcd   <= dig_next;
                  done  <= 1'b1;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            default: begin
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
